// File: rtl/alu_pipe.sv
// alu_pipe: registered RV32I execution unit between the ALU reservation station and the CDB arbiter.
// Optional RV32M multiply/divide engine is enabled by defining M_EXT_EN.
// Ports:
//   clk, rst_n (async, active low), rdy (global enable), flush (ROB clear)
//   in_valid/in_ready handshake with in_op, in_vj, in_vk, in_imm, in_robid, in_pc
//   out_valid/out_grant handshake with out_value, out_robid, out_topc
//   busy: an op is in flight or a result is held

`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif

package alu_pipe_pkg;
    localparam logic [5:0] OP_NULL = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3,
        OP_JALR = 6'd4, OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8,
        OP_BLTU = 6'd9, OP_BGEU = 6'd10, OP_ADDI = 6'd11, OP_SLTI = 6'd12, OP_SLTIU = 6'd13,
        OP_XORI = 6'd14, OP_ORI = 6'd15, OP_ANDI = 6'd16, OP_SLLI = 6'd17, OP_SRLI = 6'd18,
        OP_SRAI = 6'd19, OP_ADD = 6'd20, OP_SUB = 6'd21, OP_SLL = 6'd22, OP_SLT = 6'd23,
        OP_SLTU = 6'd24, OP_XOR = 6'd25, OP_SRL = 6'd26, OP_SRA = 6'd27, OP_OR = 6'd28,
        OP_AND = 6'd29, OP_MUL = 6'd30, OP_MULH = 6'd31, OP_MULHSU = 6'd32, OP_MULHU = 6'd33,
        OP_DIV = 6'd34, OP_DIVU = 6'd35, OP_REM = 6'd36, OP_REMU = 6'd37;
endpackage

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OP_W  = 6,
    parameter int ROB_W = `ROB_SIZE_LOG,
    parameter int DIV_W = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_vj,
    input  logic [XLEN-1:0]  in_vk,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [ROB_W-1:0] in_robid,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_grant,
    output logic [XLEN-1:0]  out_value,
    output logic [ROB_W-1:0] out_robid,
    output logic [XLEN-1:0]  out_topc,
    output logic             busy
);
    localparam int SH_W = $clog2(XLEN);

`ifdef M_EXT_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif
    state_t state;

    logic            accept, free, imm_op, eq, lt, ltu, taken, alu_ok;
    logic [XLEN-1:0] b, pc4, alu_val, alu_topc;
    logic [SH_W-1:0] sh;

    // Output register can take a new result when empty or being drained this cycle.
    assign free     = !out_valid | out_grant;
    assign in_ready = rst_n & rdy & !flush & (state == IDLE) & free;
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE) | out_valid;

    assign imm_op = (in_op >= OP_ADDI) && (in_op <= OP_SRAI);
    assign b      = imm_op ? in_imm : in_vk;
    assign sh     = b[SH_W-1:0];
    assign pc4    = in_pc + XLEN'(4);
    assign eq     = in_vj == in_vk;
    assign lt     = $signed(in_vj) < $signed(b);
    assign ltu    = in_vj < b;
    assign taken  = (in_op == OP_BEQ) ? eq : (in_op == OP_BNE) ? !eq : (in_op == OP_BLT) ? lt :
                    (in_op == OP_BGE) ? !lt : (in_op == OP_BLTU) ? ltu : !ltu;

    always_comb begin
        alu_ok   = 1'b1;
        alu_val  = '0;
        alu_topc = '0;
        case (in_op)
            OP_LUI:   alu_val = in_imm;
            OP_AUIPC: alu_val = in_pc + in_imm;
            OP_JAL: begin
                alu_val  = pc4;
                alu_topc = in_pc + in_imm;
            end
            OP_JALR: begin
                alu_val  = pc4;
                alu_topc = (in_vj + in_imm) & ~XLEN'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                alu_val  = XLEN'(taken);
                alu_topc = taken ? in_pc + in_imm : pc4;
            end
            OP_ADD, OP_ADDI:   alu_val = in_vj + b;
            OP_SUB:            alu_val = in_vj - in_vk;
            OP_SLL, OP_SLLI:   alu_val = in_vj << sh;
            OP_SLT, OP_SLTI:   alu_val = XLEN'(lt);
            OP_SLTU, OP_SLTIU: alu_val = XLEN'(ltu);
            OP_XOR, OP_XORI:   alu_val = in_vj ^ b;
            OP_OR, OP_ORI:     alu_val = in_vj | b;
            OP_AND, OP_ANDI:   alu_val = in_vj & b;
            OP_SRL, OP_SRLI:   alu_val = in_vj >> sh;
            OP_SRA, OP_SRAI:   alu_val = XLEN'($signed(in_vj) >>> sh);
            default:           alu_ok = 1'b0;
        endcase
    end

`ifdef M_EXT_EN
    localparam int CW = $clog2(DIV_W + 1);

    logic              is_mul, is_div, sgn_div, m_sa, m_sb, m_hi;
    logic              d_negq, d_negr, d_rem, d_dz, ge;
    logic [XLEN-1:0]   m_a, m_b, mul_res, d_q, d_r, d_d, d_a, q_n, r_n, quo, rmd, div_res;
    logic [XLEN:0]     r_sh, diff;
    logic [2*XLEN-1:0] prod;
    logic [ROB_W-1:0]  m_rob;
    logic [CW-1:0]     d_cnt;

    assign is_mul  = (in_op >= OP_MUL) && (in_op <= OP_MULHU);
    assign is_div  = (in_op >= OP_DIV) && (in_op <= OP_REMU);
    assign sgn_div = (in_op == OP_DIV) || (in_op == OP_REM);

    // Sign-extending to 2*XLEN lets one unsigned multiplier cover all signedness mixes.
    assign prod    = {{XLEN{m_sa & m_a[XLEN-1]}}, m_a} * {{XLEN{m_sb & m_b[XLEN-1]}}, m_b};
    assign mul_res = m_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

    // One restoring step on magnitudes; remainder stays below the divisor so XLEN+1 bits suffice.
    assign r_sh    = {d_r, d_q[XLEN-1]};
    assign diff    = r_sh - {1'b0, d_d};
    assign ge      = !diff[XLEN];
    assign q_n     = {d_q[XLEN-2:0], ge};
    assign r_n     = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    assign quo     = d_negq ? -q_n : q_n;
    assign rmd     = d_negr ? -r_n : r_n;
    // Overflow case falls out naturally: |min|/1 = min with no negation since both signs match.
    assign div_res = d_dz ? (d_rem ? d_a : '1) : (d_rem ? rmd : quo);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_value <= '0;
            out_robid <= '0;
            out_topc  <= '0;
`ifdef M_EXT_EN
            {m_sa, m_sb, m_hi, d_negq, d_negr, d_rem, d_dz} <= '0;
            {m_a, m_b, d_q, d_r, d_d, d_a} <= '0;
            m_rob <= '0;
            d_cnt <= '0;
`endif
        end else if (rdy) begin
            if (flush) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                if (out_valid & out_grant)
                    out_valid <= 1'b0;
                case (state)
                    IDLE: begin
                        if (accept & alu_ok) begin
                            out_valid <= 1'b1;
                            out_value <= alu_val;
                            out_robid <= in_robid;
                            out_topc  <= alu_topc;
                        end
`ifdef M_EXT_EN
                        else if (accept & is_mul) begin
                            state <= MUL;
                            m_a   <= in_vj;
                            m_b   <= in_vk;
                            m_sa  <= (in_op == OP_MULH) || (in_op == OP_MULHSU);
                            m_sb  <= in_op == OP_MULH;
                            m_hi  <= in_op != OP_MUL;
                            m_rob <= in_robid;
                        end else if (accept & is_div) begin
                            state  <= DIV;
                            d_q    <= (sgn_div & in_vj[XLEN-1]) ? -in_vj : in_vj;
                            d_d    <= (sgn_div & in_vk[XLEN-1]) ? -in_vk : in_vk;
                            d_r    <= '0;
                            d_a    <= in_vj;
                            d_negq <= sgn_div & (in_vj[XLEN-1] ^ in_vk[XLEN-1]);
                            d_negr <= sgn_div & in_vj[XLEN-1];
                            d_rem  <= (in_op == OP_REM) || (in_op == OP_REMU);
                            d_dz   <= in_vk == '0;
                            d_cnt  <= CW'(DIV_W);
                            m_rob  <= in_robid;
                        end
`endif
                    end
`ifdef M_EXT_EN
                    MUL: begin
                        if (free) begin
                            state     <= IDLE;
                            out_valid <= 1'b1;
                            out_value <= mul_res;
                            out_robid <= m_rob;
                            out_topc  <= '0;
                        end
                    end
                    DIV: begin
                        // Last iteration is folded into the result load; it stalls until the output frees.
                        if (d_cnt == CW'(1)) begin
                            if (free) begin
                                state     <= IDLE;
                                out_valid <= 1'b1;
                                out_value <= div_res;
                                out_robid <= m_rob;
                                out_topc  <= '0;
                            end
                        end else begin
                            d_q   <= q_n;
                            d_r   <= r_n;
                            d_cnt <= d_cnt - CW'(1);
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif

module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int RW = `ROB_SIZE_LOG;

    logic          clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_grant = 1'b0, busy;
    logic [5:0]    in_op = '0;
    logic [31:0]   in_vj = '0, in_vk = '0, in_imm = '0, in_pc = '0, out_value, out_topc;
    logic [RW-1:0] in_robid = '0, out_robid;
    int            n_chk = 0, n_err = 0;

    alu_pipe dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_vj(in_vj),
        .in_vk(in_vk), .in_imm(in_imm), .in_robid(in_robid), .in_pc(in_pc),
        .out_valid(out_valid), .out_grant(out_grant), .out_value(out_value),
        .out_robid(out_robid), .out_topc(out_topc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic [RW-1:0] rob);
        in_op = op; in_vj = a; in_vk = b; in_imm = im; in_pc = p; in_robid = rob;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic [RW-1:0] rob);
        setop(op, a, b, im, p, rob);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic grant1(input string tag);
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                       input logic [31:0] ev, input logic [31:0] et);
        issue(op, a, b, im, p, RW'(5));
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_value"}, out_value, ev);
        chk({tag, "_topc"}, out_topc, et);
        grant1(tag);
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int k;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_value", out_value, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd1);

        issue(OP_ADD, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, RW'(3));
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_value", out_value, 32'd4);
        chk("add_robid", 32'(out_robid), 32'd3);
        chk("add_busy", 32'(busy), 32'd1);
        grant1("add");
        chk("add_idle", 32'(busy), 32'd0);

        run("blt", OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd1, 32'h120);
        run("bltu_nt", OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0, 32'h104);
        run("beq_nt", OP_BEQ, 32'd1, 32'd2, 32'h20, 32'h100, 32'd0, 32'h104);
        run("jalr", OP_JALR, 32'h205, 32'd0, 32'd0, 32'h40, 32'h44, 32'h204);
        run("jal", OP_JAL, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h40, 32'h44, 32'h30);
        run("sub_wrap", OP_SUB, 32'd0, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
        run("sra_amt", OP_SRA, 32'h8000_0000, 32'd33, 32'd0, 32'd0, 32'hC000_0000, 32'd0);
        run("slli", OP_SLLI, 32'd3, 32'd0, 32'd4, 32'd0, 32'd48, 32'd0);
        run("sltiu", OP_SLTIU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0);
        run("slt", OP_SLT, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0);
        run("lui", OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 32'h1234_5000, 32'd0);
        run("auipc", OP_AUIPC, 32'd0, 32'd0, 32'h1000, 32'h200, 32'h1200, 32'd0);

        issue(OP_NULL, 32'd1, 32'd1, 32'd0, 32'd0, RW'(1));
        chk("null_drop", 32'(out_valid), 32'd0);
        issue(6'd63, 32'd1, 32'd1, 32'd0, 32'd0, RW'(1));
        chk("undef_drop", 32'(out_valid), 32'd0);

        // backpressure: three ADDs, grant held low for 4 cycles
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, RW'(1));
        setop(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, RW'(2));
        in_valid = 1'b1;
        #1;
        chk("bp_ready_lo", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_value", out_value, 32'd2);
            chk("bp_hold_robid", 32'(out_robid), 32'd1);
        end
        out_grant = 1'b1;
        #1;
        chk("bp_ready_hi", 32'(in_ready), 32'd1);
        tick();
        chk("bp_r2_valid", 32'(out_valid), 32'd1);
        chk("bp_r2_value", out_value, 32'd4);
        chk("bp_r2_robid", 32'(out_robid), 32'd2);
        setop(OP_ADD, 32'd3, 32'd3, 32'd0, 32'd0, RW'(3));
        tick();
        chk("bp_r3_value", out_value, 32'd6);
        chk("bp_r3_robid", 32'(out_robid), 32'd3);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);
        out_grant = 1'b0;

        // flush beats a pending issue and the held result
        issue(OP_ADD, 32'd9, 32'd9, 32'd0, 32'd0, RW'(4));
        chk("fl_pre", 32'(out_valid), 32'd1);
        setop(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, RW'(6));
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_noaccept", 32'(out_valid), 32'd0);

        // rdy low freezes everything
        issue(OP_XOR, 32'hF0, 32'hFF, 32'd0, 32'd0, RW'(2));
        rdy = 1'b0;
        out_grant = 1'b1;
        #1;
        chk("rdy_ready", 32'(in_ready), 32'd0);
        tick();
        chk("rdy_hold", 32'(out_valid), 32'd1);
        chk("rdy_value", out_value, 32'h0F);
        rdy = 1'b1;
        tick();
        out_grant = 1'b0;
        chk("rdy_drain", 32'(out_valid), 32'd0);

        // async reset while a result is held
        issue(OP_OR, 32'h5, 32'hA, 32'd0, 32'd0, RW'(7));
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_value", out_value, 32'd0);
        chk("arst_robid", 32'(out_robid), 32'd0);
        tick();
        rst_n = 1'b1;
        run("post_rst", OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 32'd3, 32'd0);

`ifdef M_EXT_EN
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, RW'(2));
        chk("div_ready_lo", 32'(in_ready), 32'd0);
        wait_valid(k);
        chk("div_latency", 32'(k), 32'd33);
        chk("div_ovf", out_value, 32'h8000_0000);
        chk("div_robid", 32'(out_robid), 32'd2);
        grant1("div");

        issue(OP_DIVU, 32'd1234, 32'd0, 32'd0, 32'd0, RW'(1));
        wait_valid(k);
        chk("divu_z", out_value, 32'hFFFF_FFFF);
        grant1("divu");
        issue(OP_REM, 32'd7, 32'd0, 32'd0, 32'd0, RW'(1));
        wait_valid(k);
        chk("rem_z", out_value, 32'd7);
        grant1("rem");
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, RW'(1));
        wait_valid(k);
        chk("rem_neg", out_value, 32'hFFFF_FFFF);
        grant1("remn");
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, RW'(1));
        wait_valid(k);
        chk("div_neg", out_value, 32'hFFFF_FFFD);
        grant1("divn");

        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, RW'(3));
        chk("mul_ready_lo", 32'(in_ready), 32'd0);
        wait_valid(k);
        chk("mul_latency", 32'(k), 32'd2);
        chk("mulhu", out_value, 32'hFFFF_FFFE);
        grant1("mulhu");
        issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, RW'(3));
        wait_valid(k);
        chk("mulh", out_value, 32'd0);
        grant1("mulh");
        issue(OP_MUL, 32'd6, 32'hFFFF_FFFE, 32'd0, 32'd0, RW'(3));
        wait_valid(k);
        chk("mul", out_value, 32'hFFFF_FFF4);
        grant1("mul");

        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, RW'(2));
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_div_busy", 32'(busy), 32'd0);
        chk("arst_div_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("arst_div_noleak", 32'(out_valid), 32'd0);
        run("post_div_rst", OP_ADD, 32'd4, 32'd5, 32'd0, 32'd0, 32'd9, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
